// File: rtl/issue_rr_arbiter_9b.sv
// issue_rr_arbiter_9b: round-robin grant over 9 issue slots, fed by an external rotate-right shifter.
// Optional ISSUE_ARB_ROT_CHECK_EN cross-checks rot_req against an internally computed rotation.
module issue_rr_arbiter_9b #(
   parameter logic [3:0] RST_PTR = 4'd8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] req_vec,
   input  logic [8:0] rot_req,
   output logic [3:0] rot_amt,
   output logic       grant_valid,
   input  logic       grant_ready,
   output logic [3:0] grant_idx,
   output logic [8:0] grant_onehot,
   output logic       rot_err
);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t     state_q;
   logic [3:0] ptr_q, idx_q, k, idx_d;
   logic [8:0] onehot_q, eff_req;
   logic [4:0] sum;
   logic       valid_q, err_q, err_d;

   assign rot_amt = (ptr_q == 4'd8) ? 4'd0 : ptr_q + 4'd1;

`ifdef ISSUE_ARB_ROT_CHECK_EN
   logic [17:0] dbl;
   // The internal rotation is always used: it equals rot_req whenever the shifter is healthy.
   assign dbl     = {req_vec, req_vec} >> rot_amt;
   assign eff_req = dbl[8:0];
   assign err_d   = err_q | (eff_req != rot_req);
`else
   logic unused_req;
   assign unused_req = ^req_vec;
   assign eff_req    = rot_req;
   assign err_d      = 1'b0;
`endif

   always_comb begin
      k = 4'd0;
      for (int i = 8; i >= 0; i--) if (eff_req[i]) k = 4'(i);
   end

   // 5-bit sum so k=8, rot_amt=8 does not wrap before the mod-9 correction.
   assign sum   = {1'b0, k} + {1'b0, rot_amt};
   assign idx_d = (sum > 5'd8) ? 4'(sum - 5'd9) : sum[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= RST_PTR;
         idx_q    <= 4'd0;
         onehot_q <= 9'd0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= err_d;
         if (state_q == IDLE) begin
            if (|eff_req) begin
               idx_q    <= idx_d;
               onehot_q <= 9'd1 << idx_d;
               valid_q  <= 1'b1;
               state_q  <= HOLD;
            end
         end else if (grant_ready) begin
            ptr_q   <= idx_q;
            valid_q <= 1'b0;
            state_q <= IDLE;
         end
      end
   end

   assign grant_valid  = valid_q;
   assign grant_idx    = idx_q;
   assign grant_onehot = onehot_q;
   assign rot_err      = err_q;
endmodule

// File: tb/tb_issue_rr_arbiter_9b.sv
// tb_issue_rr_arbiter_9b: directed checks of the round-robin arbiter with a behavioural shifter in the loop.
module tb_issue_rr_arbiter_9b;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [8:0]  req_vec = 9'd0;
   logic [8:0]  rot_req;
   logic [3:0]  rot_amt;
   logic        grant_valid;
   logic        grant_ready = 1'b0;
   logic [3:0]  grant_idx;
   logic [8:0]  grant_onehot;
   logic        rot_err;
   logic        force_zero = 1'b0;
   logic [17:0] shifted;
   int          n_cmp = 0;
   int          n_bad = 0;

   issue_rr_arbiter_9b dut (
      .clk(clk), .rst_n(rst_n), .req_vec(req_vec), .rot_req(rot_req), .rot_amt(rot_amt),
      .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_idx(grant_idx),
      .grant_onehot(grant_onehot), .rot_err(rot_err)
   );

   always #5 clk = ~clk;

   // Behavioural circular shifter: bit k of rot_req is source (k + rot_amt) mod 9.
   assign shifted = {req_vec, req_vec} >> rot_amt;
   assign rot_req = force_zero ? 9'd0 : shifted[8:0];

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      @(negedge clk);
      check("rst_valid", 9'(grant_valid), 9'd0);
      check("rst_idx", 9'(grant_idx), 9'd0);
      check("rst_onehot", grant_onehot, 9'd0);
      check("rst_err", 9'(rot_err), 9'd0);
      check("rst_rot_amt", 9'(rot_amt), 9'd0);
      rst_n   = 1'b1;
      req_vec = 9'h001;
      @(negedge clk);
      check("first_valid", 9'(grant_valid), 9'd1);
      check("first_idx", 9'(grant_idx), 9'd0);
      check("first_onehot", grant_onehot, 9'h001);
      @(negedge clk);
      check("ready_low_hold", 9'(grant_valid), 9'd1);
      grant_ready = 1'b1;
      @(negedge clk);
      check("accept_valid", 9'(grant_valid), 9'd0);
      check("accept_rot_amt", 9'(rot_amt), 9'd1);

      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      req_vec = 9'h1FF;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("fair_rot_amt_%0d", i), 9'(rot_amt), 9'(i));
         @(negedge clk);
         check($sformatf("fair_valid_%0d", i), 9'(grant_valid), 9'd1);
         check($sformatf("fair_idx_%0d", i), 9'(grant_idx), 9'(i));
         check($sformatf("fair_onehot_%0d", i), grant_onehot, 9'd1 << i);
         @(negedge clk);
         check($sformatf("fair_bubble_%0d", i), 9'(grant_valid), 9'd0);
      end

      req_vec = 9'h101;
      check("wrap_rot_amt", 9'(rot_amt), 9'd0);
      @(negedge clk);
      check("wrap_idx0", 9'(grant_idx), 9'd0);
      @(negedge clk);
      check("wrap_rot_amt1", 9'(rot_amt), 9'd1);
      @(negedge clk);
      check("wrap_idx8", 9'(grant_idx), 9'd8);
      check("wrap_onehot8", grant_onehot, 9'h100);
      @(negedge clk);

      grant_ready = 1'b0;
      req_vec     = 9'h008;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) req_vec = 9'h000;
         check($sformatf("hold_valid_%0d", i), 9'(grant_valid), 9'd1);
         check($sformatf("hold_idx_%0d", i), 9'(grant_idx), 9'd3);
         @(negedge clk);
      end
      grant_ready = 1'b1;
      @(negedge clk);
      check("hold_release_valid", 9'(grant_valid), 9'd0);
      check("hold_release_rot_amt", 9'(rot_amt), 9'd4);
      @(negedge clk);
      check("idle_no_req", 9'(grant_valid), 9'd0);

      grant_ready = 1'b0;
      req_vec     = 9'h020;
      @(negedge clk);
      check("pre_rst_idx", 9'(grant_idx), 9'd5);
      check("pre_rst_valid", 9'(grant_valid), 9'd1);
      req_vec = 9'h000;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 9'(grant_valid), 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_rot_amt", 9'(rot_amt), 9'd0);

      force_zero = 1'b1;
      req_vec    = 9'h010;
      @(negedge clk);
`ifdef ISSUE_ARB_ROT_CHECK_EN
      check("rotchk_err", 9'(rot_err), 9'd1);
      check("rotchk_valid", 9'(grant_valid), 9'd1);
      check("rotchk_idx", 9'(grant_idx), 9'd4);
      force_zero  = 1'b0;
      grant_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rotchk_sticky", 9'(rot_err), 9'd1);
`else
      check("rotchk_err", 9'(rot_err), 9'd0);
      check("rotchk_valid", 9'(grant_valid), 9'd0);
      @(negedge clk);
      check("rotchk_still_idle", 9'(grant_valid), 9'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
